// File: rtl/traffic_pkg.sv
// Shared light encodings, state codes and default timing for the
// intersection scheduler and its phase timer.
package traffic_pkg;

   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;

   localparam logic [2:0] S_NS_G = 3'd0;
   localparam logic [2:0] S_NS_Y = 3'd1;
   localparam logic [2:0] S_EW_G = 3'd2;
   localparam logic [2:0] S_EW_Y = 3'd3;
   localparam logic [2:0] S_AR   = 3'd4;
   localparam logic [2:0] S_PED  = 3'd5;

   localparam int unsigned MIN_GREEN_DEF = 4;
   localparam int unsigned MAX_GREEN_DEF = 10;
   localparam int unsigned YELLOW_T_DEF  = 2;
   localparam int unsigned ALLRED_T_DEF  = 1;
   localparam int unsigned PED_T_DEF     = 5;

   typedef enum logic [1:0] {
      SRV_NS  = 2'd0,
      SRV_EW  = 2'd1,
      SRV_PED = 2'd2
   } served_e;

   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } dir_e;

endpackage

// File: rtl/intersection_scheduler_if.sv
// Request inputs and light/status outputs of the intersection scheduler.
// master: controller side (drives requests); slave: the scheduler.
interface intersection_scheduler_if;

   logic       ns_req;
   logic       ew_req;
   logic       ped_req;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       ped_walk;
   logic       ped_pending;
   logic [2:0] phase;

   modport master (
      output ns_req, ew_req, ped_req,
      input  ns_light, ew_light, ped_walk, ped_pending, phase
   );

   modport slave (
      input  ns_req, ew_req, ped_req,
      output ns_light, ew_light, ped_walk, ped_pending, phase
   );

endinterface

// File: rtl/phase_timer.sv
// Cycles-in-phase counter: clears on clear_i, else counts up to 15.
// Ports: clk, rst_n, clear_i (state change), count_o (4-bit count).
module phase_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear_i,
   output logic [3:0] count_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = 4'd0;
      else if (cnt_q != 4'hF)
         cnt_d = cnt_q + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 4'd0;
      else        cnt_q <= cnt_d;
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/intersection_scheduler.sv
// Two-way intersection light FSM with pedestrian walk phase.
// Ports: clk, rst_n, bus (intersection_scheduler_if.slave).
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned MIN_GREEN = MIN_GREEN_DEF,
   parameter int unsigned MAX_GREEN = MAX_GREEN_DEF,
   parameter int unsigned YELLOW_T  = YELLOW_T_DEF,
   parameter int unsigned ALLRED_T  = ALLRED_T_DEF,
   parameter int unsigned PED_T     = PED_T_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   intersection_scheduler_if.slave  bus
);

   // Timer values marking the last cycle of each interval
   localparam logic [3:0] MIN_T = 4'(MIN_GREEN - 1);
   localparam logic [3:0] MAX_T = 4'(MAX_GREEN - 1);
   localparam logic [3:0] YEL_T = 4'(YELLOW_T - 1);
   localparam logic [3:0] AR_T  = 4'(ALLRED_T - 1);
   localparam logic [3:0] WLK_T = 4'(PED_T - 1);

   logic [2:0] state_q, state_d;
   logic [3:0] timer;
   logic       pend_q, pend_d;
   served_e    srv_q, srv_d;
   dir_e       dir_q, dir_d;
   logic       chg;
   logic       ns_go, ew_go;
   logic       opp_req, own_req;
   logic [2:0] grant;

   phase_timer u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (chg),
      .count_o (timer)
   );

   assign ns_go = (timer >= MIN_T) && (bus.ew_req || pend_q) &&
                  (!bus.ns_req || timer >= MAX_T);
   assign ew_go = (timer >= MIN_T) && (bus.ns_req || pend_q) &&
                  (!bus.ew_req || timer >= MAX_T);

   assign opp_req = (dir_q == DIR_NS) ? bus.ew_req : bus.ns_req;
   assign own_req = (dir_q == DIR_NS) ? bus.ns_req : bus.ew_req;

   // All-red exit: walk first unless it was just served, then
   // prefer the direction that did not have the last green
   always_comb begin
      grant = S_NS_G;
      if (pend_q && srv_q != SRV_PED)
         grant = S_PED;
      else if (opp_req)
         grant = (dir_q == DIR_NS) ? S_EW_G : S_NS_G;
      else if (own_req)
         grant = (dir_q == DIR_NS) ? S_NS_G : S_EW_G;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_NS_G: if (ns_go) state_d = S_NS_Y;
         S_EW_G: if (ew_go) state_d = S_EW_Y;
         S_NS_Y,
         S_EW_Y: if (timer >= YEL_T) state_d = S_AR;
         S_PED:  if (timer >= WLK_T) state_d = S_AR;
         S_AR:   if (timer >= AR_T)  state_d = grant;
         default: state_d = S_NS_G;
      endcase
   end

   assign chg = (state_d != state_q);

   always_comb begin
      srv_d = srv_q;
      dir_d = dir_q;
      if (chg) begin
         unique case (state_d)
            S_NS_G: begin srv_d = SRV_NS; dir_d = DIR_NS; end
            S_EW_G: begin srv_d = SRV_EW; dir_d = DIR_EW; end
            S_PED:  srv_d = SRV_PED;
            default: ;
         endcase
      end
   end

   // A request arriving on the walk-entry edge stays pending
   assign pend_d = bus.ped_req |
                   (pend_q & ~(chg && state_d == S_PED));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_NS_G;
         pend_q  <= 1'b0;
         srv_q   <= SRV_NS;
         dir_q   <= DIR_NS;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         srv_q   <= srv_d;
         dir_q   <= dir_d;
      end
   end

   always_comb begin
      bus.ns_light = LT_RED;
      bus.ew_light = LT_RED;
      bus.ped_walk = 1'b0;
      unique case (state_q)
         S_NS_G: bus.ns_light = LT_GRN;
         S_NS_Y: bus.ns_light = LT_YEL;
         S_EW_G: bus.ew_light = LT_GRN;
         S_EW_Y: bus.ew_light = LT_YEL;
         S_PED:  bus.ped_walk = 1'b1;
         default: ;
      endcase
   end

   assign bus.ped_pending = pend_q;
   assign bus.phase       = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler: directed timing
// scenarios plus randomized requests against a phase-level model.
module tb_intersection_scheduler;
   import traffic_pkg::*;

   localparam int MIN_G = 4;
   localparam int MAX_G = 10;
   localparam int YEL   = 2;
   localparam int ALLR  = 1;
   localparam int WALK  = 5;

   localparam int M_NSG = 0;
   localparam int M_NSY = 1;
   localparam int M_EWG = 2;
   localparam int M_EWY = 3;
   localparam int M_AR  = 4;
   localparam int M_PED = 5;

   logic clk;
   logic rst_n;
   intersection_scheduler_if bif();

   intersection_scheduler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vecs;
   int errs;
   bit chk_en;

   int m_ph;
   int m_el;
   bit m_pend;
   int m_srv;
   int m_dir;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ph   = M_NSG;
      m_el   = 0;
      m_pend = 1'b0;
      m_srv  = 0;
      m_dir  = 0;
   endtask

   task automatic model_step();
      int nx;
      bit ns, ew, opp, own;
      ns = bif.ns_req;
      ew = bif.ew_req;
      nx = m_ph;
      case (m_ph)
         M_NSG: if (m_el >= MIN_G - 1 && (ew || m_pend) &&
                    (!ns || m_el >= MAX_G - 1)) nx = M_NSY;
         M_EWG: if (m_el >= MIN_G - 1 && (ns || m_pend) &&
                    (!ew || m_el >= MAX_G - 1)) nx = M_EWY;
         M_NSY, M_EWY: if (m_el >= YEL - 1) nx = M_AR;
         M_PED: if (m_el >= WALK - 1) nx = M_AR;
         default: if (m_el >= ALLR - 1) begin
            opp = (m_dir == 0) ? ew : ns;
            own = (m_dir == 0) ? ns : ew;
            if (m_pend && m_srv != 2) nx = M_PED;
            else if (opp) nx = (m_dir == 0) ? M_EWG : M_NSG;
            else if (own) nx = (m_dir == 0) ? M_NSG : M_EWG;
            else nx = M_NSG;
         end
      endcase
      m_pend = bif.ped_req || (m_pend && !(nx == M_PED && m_ph != M_PED));
      if (nx != m_ph) begin
         m_el = 0;
         if (nx == M_NSG) begin m_srv = 0; m_dir = 0; end
         if (nx == M_EWG) begin m_srv = 1; m_dir = 1; end
         if (nx == M_PED) m_srv = 2;
      end else begin
         m_el++;
      end
      m_ph = nx;
   endtask

   function automatic logic [10:0] model_out();
      logic [2:0] ns, ew, cd;
      ns = (m_ph == M_NSG) ? LT_GRN : (m_ph == M_NSY) ? LT_YEL : LT_RED;
      ew = (m_ph == M_EWG) ? LT_GRN : (m_ph == M_EWY) ? LT_YEL : LT_RED;
      case (m_ph)
         M_NSG: cd = S_NS_G;
         M_NSY: cd = S_NS_Y;
         M_EWG: cd = S_EW_G;
         M_EWY: cd = S_EW_Y;
         M_AR:  cd = S_AR;
         default: cd = S_PED;
      endcase
      return {ns, ew, (m_ph == M_PED), m_pend, cd};
   endfunction

   always @(posedge clk) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin
      if (chk_en)
         chk("model", {bif.ns_light, bif.ew_light, bif.ped_walk,
                       bif.ped_pending, bif.phase}, model_out());
   end

   task automatic do_reset(input bit ns, input bit ew, input bit ped);
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      bif.ns_req  = ns;
      bif.ew_req  = ew;
      bif.ped_req = ped;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [2:0] ns_s [0:59];
   logic [2:0] ew_s [0:59];
   logic       wk_s [0:59];
   logic       pd_s [0:59];
   int cnt;
   int viol;
   int peds;
   int last_g;
   bit pw_prev;
   bit eg_prev;

   initial begin
      vecs   = 0;
      errs   = 0;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      bif.ns_req  = 1'b0;
      bif.ew_req  = 1'b0;
      bif.ped_req = 1'b0;
      model_reset();
      #1;
      chk("rst_ns", bif.ns_light, 3'b001);
      chk("rst_ew", bif.ew_light, 3'b100);
      chk("rst_walk", bif.ped_walk, 1'b0);
      chk("rst_pend", bif.ped_pending, 1'b0);
      chk_en = 1'b1;

      // idle: NS green holds
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (bif.ns_light != 3'b001 || bif.ew_light != 3'b100 ||
             bif.ped_walk) cnt++;
      end
      chk("idle_hold", cnt, 0);

      // EW only: 4 green, 2 yellow, 1 all-red, EW green at 7
      do_reset(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         #1;
         ns_s[k] = bif.ns_light;
         ew_s[k] = bif.ew_light;
         @(negedge clk);
      end
      cnt = 0;
      for (int k = 0; k < 10; k++) if (ns_s[k] == 3'b001) cnt++;
      chk("ew_only_ns_green_len", cnt, 4);
      chk("ew_only_y4", ns_s[4], 3'b010);
      chk("ew_only_y5", ns_s[5], 3'b010);
      chk("ew_only_ar6", {ns_s[6], ew_s[6]}, 6'b100100);
      chk("ew_only_g7", {ns_s[7], ew_s[7]}, 6'b100001);

      // both requesting: 10 green each, alternating
      do_reset(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 30; k++) begin
         #1;
         ns_s[k] = bif.ns_light;
         ew_s[k] = bif.ew_light;
         @(negedge clk);
      end
      cnt = 0;
      for (int k = 0; k < 30; k++) if (ns_s[k] == 3'b001 && k < 26) cnt++;
      chk("both_ns_green_len", cnt, 10);
      cnt = 0;
      for (int k = 0; k < 30; k++) if (ew_s[k] == 3'b001) cnt++;
      chk("both_ew_green_len", cnt, 10);
      chk("both_ns_y10", ns_s[10], 3'b010);
      chk("both_ew_g13", ew_s[13], 3'b001);
      chk("both_ew_y23", ew_s[23], 3'b010);
      chk("both_ns_g26", ns_s[26], 3'b001);

      // single pedestrian pulse during NS green
      do_reset(1'b0, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      bif.ped_req = 1'b1;
      @(negedge clk);
      bif.ped_req = 1'b0;
      for (int j = 0; j < 20; j++) begin
         #1;
         ns_s[j] = bif.ns_light;
         ew_s[j] = bif.ew_light;
         wk_s[j] = bif.ped_walk;
         pd_s[j] = bif.ped_pending;
         @(negedge clk);
      end
      chk("ped_pend_set", pd_s[0], 1'b1);
      chk("ped_ns_y", ns_s[1], 3'b010);
      cnt = 0;
      for (int j = 0; j < 20; j++) if (wk_s[j]) cnt++;
      chk("ped_walk_len", cnt, 5);
      chk("ped_walk_first", {wk_s[3], wk_s[4]}, 2'b01);
      chk("ped_pend_clr", pd_s[5], 1'b0);
      chk("ped_back_ns", {ns_s[10], ew_s[10]}, 6'b001100);

      // async reset in the middle of the walk
      do_reset(1'b0, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      bif.ped_req = 1'b1;
      @(negedge clk);
      bif.ped_req = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      chk("mid_ped_walk", bif.ped_walk, 1'b1);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_walk", bif.ped_walk, 1'b0);
      chk("async_ns", bif.ns_light, 3'b001);
      chk("async_pend", bif.ped_pending, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // walk held with EW traffic: walk never twice in a row
      do_reset(1'b0, 1'b1, 1'b1);
      viol = 0;
      peds = 0;
      last_g = 0;
      pw_prev = 1'b0;
      eg_prev = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (bif.ped_walk && !pw_prev) begin
            peds++;
            if (last_g == 2) viol++;
            last_g = 2;
         end
         if (bif.ew_light == 3'b001 && !eg_prev) last_g = 1;
         pw_prev = bif.ped_walk;
         eg_prev = (bif.ew_light == 3'b001);
      end
      chk("ped_twice", viol, 0);
      chk("ped_served", (peds >= 10), 1'b1);
      bif.ped_req = 1'b0;

      // randomized traffic with occasional async reset
      do_reset(1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!rst_n) rst_n = 1'b1;
         if ($urandom_range(99) < 8) bif.ns_req = ~bif.ns_req;
         if ($urandom_range(99) < 8) bif.ew_req = ~bif.ew_req;
         bif.ped_req = ($urandom_range(99) < 4);
         if ($urandom_range(999) < 3) begin
            #2 rst_n = 1'b0;
            model_reset();
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 The block SHALL have parameter MIN_GREEN, default 4, meaning minimum green cycles per vehicle phase.
REQ-002 The block SHALL have parameter MAX_GREEN, default 10, meaning green cycles after which a contested phase is forced to yield.
REQ-003 The block SHALL have parameter YELLOW_T, default 2, meaning yellow cycles.
REQ-004 The block SHALL have parameter ALLRED_T, default 1, meaning all-red clearance cycles.
REQ-005 The block SHALL have parameter PED_T, default 5, meaning pedestrian walk cycles.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 ns_req  in  1  vehicle present north-south, level.
REQ-009 ew_req  in  1  vehicle present east-west, level.
REQ-010 ped_req  in  1  pedestrian button, any-cycle pulse or level.
REQ-011 ns_light  out  3  one-hot light: RED=100, YELLOW=010, GREEN=001.
REQ-012 ew_light  out  3  same encoding as ns_light.
REQ-013 ped_walk  out  1  walk indication.
REQ-014 ped_pending  out  1  latched pedestrian request.
REQ-015 phase  out  3  current state code, for debug.

Function
REQ-016 States SHALL be S_NS_G, S_NS_Y, S_EW_G, S_EW_Y, S_AR (all-red), S_PED.
REQ-017 Light decode SHALL be:
- S_NS_G: ns GREEN, ew RED.
- S_NS_Y: ns YELLOW, ew RED.
- S_EW_G: ns RED, ew GREEN.
- S_EW_Y: ns RED, ew YELLOW.
- S_AR: both RED.
- S_PED: both RED, ped_walk=1.
- Other states: ped_walk=0.
- Outputs SHALL be a combinational decode of the registered state, with zero latency.
REQ-018 The 4-bit timer SHALL clear on every state change and otherwise increment, saturating at 15.
REQ-019 The green-phase exit rule SHALL be:
- S_NS_G exits to S_NS_Y when timer>=MIN_GREEN-1 and (ew_req or ped_pending) and (ns_req==0 or timer>=MAX_GREEN-1).
- S_EW_G uses the same rule with ns and ew swapped.
- With no competing request, the green holds indefinitely.
REQ-020 Yellow SHALL last YELLOW_T cycles, then the state SHALL go to S_AR; S_PED SHALL last PED_T cycles, then the state SHALL go to S_AR.
REQ-021 S_AR SHALL last ALLRED_T cycles, then the grant SHALL resolve in this order:
- ped_pending and last_served!=PED: go to S_PED.
- Else, if the vehicle direction opposite to last_dir is requesting: go to that direction's green.
- Else, if last_dir is requesting: go to last_dir green.
- Else: go to S_NS_G.
REQ-022 last_served SHALL record NS, EW or PED on each green/walk entry; last_dir SHALL record NS or EW on each vehicle green entry.
REQ-023 ped_pending SHALL set on any cycle ped_req=1 and SHALL clear on the edge entering S_PED; a simultaneous set SHALL win, leaving the request pending.
REQ-024 PED SHALL never be granted twice consecutively, which prevents vehicle starvation.
REQ-025 Illegal state codes SHALL recover to S_NS_G on the next edge.
REQ-026 A direction SHALL never show GREEN or YELLOW while the other direction, or ped_walk, is non-RED/active.

Reset
REQ-027 On rst_n low, the following SHALL apply immediately, independent of clk:
- state=S_NS_G, timer=0, ped_pending=0, last_served=NS, last_dir=NS.
- ns_light=GREEN, ew_light=RED, ped_walk=0, phase=S_NS_G code.
REQ-028 Reset asserted mid-phase, including S_PED or yellow, SHALL abort the phase with no intermediate yellow or all-red.

Structure
REQ-029 The light encodings, state codes and default timing constants SHALL live in shared package traffic_pkg.
REQ-030 The timer (clear/increment/saturate) SHALL be the sub-module phase_timer; the FSM, request latch and decode SHALL stay in the top level.

Verification
REQ-031 Reset, all requests 0 for 50 cycles -> ns GREEN, ew RED, ped_walk=0 throughout.
REQ-032 ew_req=1 and ns_req=0 from reset release -> timing SHALL be:
- ns GREEN for 4 cycles.
- ns YELLOW for 2 cycles.
- all-red for 1 cycle.
- ew GREEN from cycle 7.
REQ-033 ns_req and ew_req both held 1 -> NS green SHALL last exactly 10 cycles, then 2 yellow, 1 all-red, EW green for 10; alternation SHALL repeat.
REQ-034 A 1-cycle ped_req pulse during NS green with no vehicle requests -> sequence and flags SHALL be:
- ped_pending=1 on the next cycle.
- NS yields after MIN_GREEN; then 2 yellow and 1 all-red.
- ped_walk=1 for 5 cycles, with ped_pending=0 after S_PED entry.
- Then all-red, then S_NS_G.
REQ-035 ped_req held 1 continuously with ew_req=1 -> PED and EW SHALL alternate, and PED SHALL never occur twice in a row.
REQ-036 rst_n pulsed low asynchronously mid-S_PED -> ped_walk=0 and ns GREEN SHALL appear before the next clk edge, with ped_pending=0.
